// File: rtl/shift_rows_pipe_pkg.sv
// shift_rows_pipe_pkg: shared row-offset and byte-layout helpers for the ShiftRows pipeline.
package shift_rows_pipe_pkg;
   localparam logic MODE_FWD = 1'b0;
   localparam logic MODE_INV = 1'b1;
   function automatic int row_off(input int nb, input int r);
      return (r == 0) ? 0 : (nb == 8 && r > 1) ? r + 1 : (nb == 7 && r == 3) ? 4 : r;
   endfunction
   function automatic int byte_pos(input int r, input int c);
      return c * 4 + r;
   endfunction
endpackage

// File: rtl/shift_rows_pipe_if.sv
// shift_rows_pipe_if: valid/ready state bus with mode and tag sideband, both directions of the unit.
interface shift_rows_pipe_if #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic               in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic [0:NB*32-1]   in_data;
   logic               out_valid;
   logic               out_ready;
   logic [TAG_W-1:0]   out_tag;
   logic [0:NB*32-1]   out_data;
   modport master (
      output in_valid, in_mode, in_tag, in_data, out_ready,
      input  in_ready, out_valid, out_tag, out_data
   );
   modport slave (
      input  in_valid, in_mode, in_tag, in_data, out_ready,
      output in_ready, out_valid, out_tag, out_data
   );
endinterface

// File: rtl/shift_rows_pipe_perm.sv
// shift_rows_pipe_perm: combinational ShiftRows/InvShiftRows byte permutation of an NB-column state.
module shift_rows_pipe_perm
   import shift_rows_pipe_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic             i_mode,
   input  logic [0:NB*32-1] i_data,
   output logic [0:NB*32-1] o_data
);
   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int FWD = (c + row_off(NB, r)) % NB;
         localparam int INV = (c - row_off(NB, r) + NB) % NB;
         assign o_data[byte_pos(r, c)*8 +: 8] = (i_mode == MODE_INV) ? i_data[byte_pos(r, INV)*8 +: 8]
                                                                      : i_data[byte_pos(r, FWD)*8 +: 8];
      end
   end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: permutes a Rijndael state on accept, then carries it through STAGES elastic registers.
module shift_rows_pipe
   import shift_rows_pipe_pkg::*;
#(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAG_W  = 4
) (
   input logic              clk,
   input logic              reset_n,
   shift_rows_pipe_if.slave i_bus
);
   localparam int W = NB * 32;
   if (NB < 4 || NB > 8 || STAGES < 1 || STAGES > 4 || TAG_W < 1) begin : g_bad_params
      $error("shift_rows_pipe: illegal NB/STAGES/TAG_W");
   end
   logic [0:W-1]       w_perm;
   logic [STAGES:0]    w_vld;
   logic [STAGES-1:0]  w_rdy;
   logic [0:W-1]       w_data [STAGES+1];
   logic [TAG_W-1:0]   w_tag  [STAGES+1];
   shift_rows_pipe_perm #(.NB(NB)) u_perm (
      .i_mode (i_bus.in_mode),
      .i_data (i_bus.in_data),
      .o_data (w_perm)
   );
   assign w_vld[0]  = i_bus.in_valid;
   assign w_data[0] = w_perm;
   assign w_tag[0]  = i_bus.in_tag;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             r_vld;
      logic [0:W-1]     r_data;
      logic [TAG_W-1:0] r_tag;
      // A stage can load if any register at or after it has a hole, or the sink drains.
      assign w_rdy[k] = i_bus.out_ready || !(&w_vld[STAGES:k+1]);
      always_ff @(posedge clk) begin
         if (!reset_n)
            r_vld <= 1'b0;
         else if (w_rdy[k])
            r_vld <= w_vld[k];
         if (w_rdy[k] && w_vld[k]) begin
            r_data <= w_data[k];
            r_tag  <= w_tag[k];
         end
      end
      assign w_vld[k+1]  = r_vld;
      assign w_data[k+1] = r_data;
      assign w_tag[k+1]  = r_tag;
   end
   assign i_bus.in_ready  = w_rdy[0];
   assign i_bus.out_valid = w_vld[STAGES];
   assign i_bus.out_data  = w_data[STAGES];
   assign i_bus.out_tag   = w_tag[STAGES];
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed and randomised checks of several shift_rows_pipe configurations against a byte model.
module tb_shift_rows_pipe;
   localparam int N = 5;
   localparam int NBS [N] = '{4, 8, 4, 6, 7};
   localparam int STS [N] = '{1, 3, 2, 2, 1};
   localparam logic [255:0] V_IN  = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] V_INV = 256'h000d0a0704010e0b0805020f0c090603;
   localparam logic [255:0] V_FWD = 256'h00050a0f04090e03080d02070c01060b;
   typedef struct {logic [255:0] d; logic [3:0] t; int c;} ent_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic iv [N];
   logic im [N];
   logic [3:0] it [N];
   logic [255:0] id [N];
   logic ordy [N];
   logic ov [N];
   logic irdy [N];
   logic [3:0] ot [N];
   logic [255:0] od [N];
   ent_t q [N][$];
   int acc [N];
   int em [N];
   bit lat [N];
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < N; g++) begin : g_dut
      shift_rows_pipe_if #(.NB(NBS[g]), .TAG_W(4)) bus ();
      shift_rows_pipe #(.NB(NBS[g]), .STAGES(STS[g]), .TAG_W(4)) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .i_bus   (bus)
      );
      assign bus.in_valid  = iv[g];
      assign bus.in_mode   = im[g];
      assign bus.in_tag    = it[g];
      assign bus.in_data   = id[g][NBS[g]*32-1:0];
      assign bus.out_ready = ordy[g];
      assign ov[g]   = bus.out_valid;
      assign irdy[g] = bus.in_ready;
      assign ot[g]   = bus.out_tag;
      assign od[g]   = 256'(bus.out_data);
   end
   function automatic logic [255:0] ref_sr(input int nb, input logic inv, input logic [255:0] d);
      int off [4] = '{0, 1, 2, 3};
      logic [255:0] o = '0;
      if (nb == 7) off[3] = 4;
      if (nb == 8) begin
         off[2] = 3;
         off[3] = 4;
      end
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) begin
            int s = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
            o[(nb*4-1-(c*4+r))*8 +: 8] = d[(nb*4-1-(s*4+r))*8 +: 8];
         end
      return o;
   endfunction
   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Settle, score this cycle's transfers (they happen at the coming edge), then advance to the next negedge.
   task automatic tick();
      #1;
      for (int i = 0; i < N; i++) begin
         if (reset_n && ov[i] && ordy[i]) begin
            em[i]++;
            chk($sformatf("sb_nonempty%0d", i), 256'(q[i].size() != 0), 256'(1));
            if (q[i].size() != 0) begin
               ent_t e = q[i].pop_front();
               chk($sformatf("sb_data%0d", i), od[i], e.d);
               chk($sformatf("sb_tag%0d", i), 256'(ot[i]), 256'(e.t));
               if (lat[i]) chk($sformatf("sb_latency%0d", i), 256'(cyc - e.c), 256'(STS[i]));
            end
         end
         if (reset_n && iv[i] && irdy[i]) begin
            q[i].push_back('{ref_sr(NBS[i], im[i], id[i]), it[i], cyc});
            acc[i]++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask
   task automatic dir(input logic m, input logic [3:0] t, input logic [255:0] d, input logic [255:0] e);
      iv[0] = 1'b1;
      im[0] = m;
      it[0] = t;
      id[0] = d;
      tick();
      iv[0] = 1'b0;
      chk("dir_valid", 256'(ov[0]), 256'(1));
      chk("dir_data", od[0], e);
      chk("dir_tag", 256'(ot[0]), 256'(t));
   endtask
   initial begin
      logic [255:0] dv [4];
      int snap [N];
      for (int i = 0; i < N; i++) begin
         iv[i] = 1'b0; im[i] = 1'b0; it[i] = '0; id[i] = '0; ordy[i] = 1'b1;
         acc[i] = 0; em[i] = 0; lat[i] = 1'b0;
      end
      @(negedge clk);
      tick();
      tick();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_out_valid%0d", i), 256'(ov[i]), 256'(0));
         chk($sformatf("rst_in_ready%0d", i), 256'(irdy[i]), 256'(1));
      end
      reset_n = 1'b1;
      // NB=4, single stage: hand-computed vectors and a round trip
      dir(1'b1, 4'h5, V_IN, V_INV);
      dir(1'b0, 4'h6, V_IN, V_FWD);
      dir(1'b1, 4'h7, V_FWD, V_IN);
      dir(1'b0, 4'h8, V_INV, V_IN);
      tick();
      // NB=8, three stages, alternating mode at full rate
      lat[1] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         iv[1] = 1'b1;
         im[1] = k[0];
         it[1] = 4'(k);
         id[1] = rnd256();
         tick();
         chk("b_in_ready", 256'(irdy[1]), 256'(1));
      end
      iv[1] = 1'b0;
      repeat (4) tick();
      chk("b_emitted", 256'(em[1]), 256'(12));
      lat[1] = 1'b0;
      // NB=4, two stages: fill under backpressure, then release
      for (int k = 0; k < 4; k++) dv[k] = rnd256();
      ordy[2] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         iv[2] = 1'b1;
         im[2] = 1'b0;
         it[2] = 4'(8 + acc[2]);
         id[2] = dv[acc[2]];
         tick();
         if (k >= 1) begin
            chk("c_hold_data", od[2], ref_sr(4, 1'b0, dv[0]));
            chk("c_hold_tag", 256'(ot[2]), 256'(8));
            chk("c_in_ready", 256'(irdy[2]), 256'(0));
         end
      end
      chk("c_accepted", 256'(acc[2]), 256'(2));
      ordy[2] = 1'b1;
      for (int k = 0; k < 20 && acc[2] < 4; k++) begin
         it[2] = 4'(8 + acc[2]);
         id[2] = dv[acc[2]];
         tick();
      end
      iv[2] = 1'b0;
      repeat (4) tick();
      chk("c_emitted", 256'(em[2]), 256'(4));
      chk("c_drained", 256'(q[2].size()), 256'(0));
      // random valid/ready on NB=4,6,7
      for (int k = 0; k < 8000; k++) begin
         for (int i = 0; i < N; i++) begin
            if (i == 0 || i == 3 || i == 4) begin
               iv[i] = 1'($urandom_range(0, 1));
               ordy[i] = 1'($urandom_range(0, 1));
               im[i] = 1'($urandom_range(0, 1));
               it[i] = 4'($urandom_range(0, 15));
               id[i] = rnd256();
            end
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         iv[i] = 1'b0;
         ordy[i] = 1'b1;
      end
      repeat (5) tick();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("r_balance%0d", i), 256'(em[i]), 256'(acc[i]));
         chk($sformatf("r_drained%0d", i), 256'(q[i].size()), 256'(0));
      end
      // reset with the pipes full: nothing in flight may ever come out
      for (int i = 1; i <= 2; i++) begin
         ordy[i] = 1'b0;
         iv[i] = 1'b1;
         it[i] = 4'hA;
         id[i] = rnd256();
      end
      repeat (6) tick();
      chk("e_full1", 256'(ov[1]), 256'(1));
      chk("e_full2", 256'(ov[2]), 256'(1));
      reset_n = 1'b0;
      tick();
      for (int i = 1; i <= 2; i++) begin
         chk($sformatf("e_out_valid%0d", i), 256'(ov[i]), 256'(0));
         chk($sformatf("e_in_ready%0d", i), 256'(irdy[i]), 256'(1));
         q[i].delete();
         snap[i] = em[i];
         iv[i] = 1'b0;
         ordy[i] = 1'b1;
      end
      reset_n = 1'b1;
      repeat (6) tick();
      for (int i = 1; i <= 2; i++) chk($sformatf("e_no_emit%0d", i), 256'(em[i]), 256'(snap[i]));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
